// File: rtl/core_run_pkg.sv
// Shared types and constants for the core run controller/monitor.
package core_run_pkg;

    typedef enum logic [1:0] {RESET_HOLD, RUN, DRAIN, DONE} run_state_e;

    typedef enum logic [1:0] {ST_NONE, ST_HALT, ST_TIMEOUT, ST_HANG} run_status_e;

    localparam logic [31:0] RV_ECALL = 32'h00000073;

    // Bits needed to hold the terminal value n-1 of a counter (at least 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/run_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module run_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/core_run_monitor.sv
// Run controller for the RV32I core: holds core reset, counts cycles and ends the
// run on halt instruction, PC hang or cycle timeout with a sticky status.
module core_run_monitor
    import core_run_pkg::*;
#(
    parameter int unsigned       XLEN         = 32,
    parameter int unsigned       CNT_W        = 32,
    parameter int unsigned       RESET_CYCLES = 2,
    parameter int unsigned       MAX_CYCLES   = 500,
    parameter int unsigned       STALL_LIMIT  = 16,
    parameter logic [XLEN-1:0]   HALT_INSTR   = XLEN'(RV_ECALL),
    parameter int unsigned       HALT_DRAIN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  instr_t,
    input  logic [XLEN-1:0]  pco_out,
    input  logic             restart,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [XLEN-1:0]  last_pc
);

    localparam int unsigned HOLD_W  = cnt_width(RESET_CYCLES);
    localparam int unsigned STALL_W = cnt_width(STALL_LIMIT);
    localparam int unsigned DRAIN_W = cnt_width(HALT_DRAIN);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((HALT_DRAIN == 0) ? 0 : HALT_DRAIN - 1);
    localparam logic [CNT_W-1:0]   CYC_LAST   = CNT_W'(MAX_CYCLES - 1);

    run_state_e        state_q;
    run_status_e       status_q;
    logic [XLEN-1:0]   prev_pc_q;
    logic              prev_valid_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [DRAIN_W-1:0] drain_cnt;

    logic in_hold, in_run, in_drain, rearm;
    logic is_halt, pc_same, hang_hit, timeout_hit;

    always_comb begin
        in_hold     = (state_q == RESET_HOLD);
        in_run      = (state_q == RUN);
        in_drain    = (state_q == DRAIN);
        rearm       = (state_q == DONE) && restart;
        is_halt     = (instr_t == HALT_INSTR);
        // prev_pc is stale on the first RUN cycle, so no stall compare then
        pc_same     = prev_valid_q && (pco_out == prev_pc_q);
        hang_hit    = pc_same && (stall_cnt == STALL_LAST);
        timeout_hit = (cycle_cnt == CYC_LAST);
    end

    run_sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (rearm),
        .en  (in_hold),
        .cnt (hold_cnt)
    );

    run_sat_counter #(.W(STALL_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (rearm || (in_run && !pc_same)),
        .en  (in_run && pc_same),
        .cnt (stall_cnt)
    );

    run_sat_counter #(.W(DRAIN_W)) u_drain_cnt (
        .clk (clk),
        .rst (rst),
        .clr (rearm),
        .en  (in_drain),
        .cnt (drain_cnt)
    );

    run_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (rearm),
        .en  (in_run || in_drain),
        .cnt (cycle_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RESET_HOLD;
            status_q     <= ST_NONE;
            core_rst     <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            last_pc      <= '0;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                RESET_HOLD: begin
                    prev_valid_q <= 1'b0;
                    if (hold_cnt == HOLD_LAST) begin
                        state_q  <= RUN;
                        core_rst <= 1'b0;
                        running  <= 1'b1;
                    end
                end
                RUN: begin
                    prev_pc_q    <= pco_out;
                    prev_valid_q <= 1'b1;
                    last_pc      <= pco_out;
                    if (is_halt) begin
                        if (HALT_DRAIN == 0) begin
                            state_q  <= DONE;
                            status_q <= ST_HALT;
                            running  <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (hang_hit) begin
                        state_q  <= DONE;
                        status_q <= ST_HANG;
                        running  <= 1'b0;
                        done     <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q  <= DONE;
                        status_q <= ST_TIMEOUT;
                        running  <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                DRAIN: begin
                    last_pc <= pco_out;
                    if (drain_cnt == DRAIN_LAST) begin
                        state_q  <= DONE;
                        status_q <= ST_HALT;
                        running  <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    if (restart) begin
                        state_q  <= RESET_HOLD;
                        status_q <= ST_NONE;
                        core_rst <= 1'b1;
                        done     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign status = status_q;

endmodule

// File: tb/tb_core_run_monitor.sv
// Directed bench for core_run_monitor with default parameters.
module tb_core_run_monitor;

    localparam logic [31:0] ECALL = 32'h00000073;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_t;
    logic [31:0] pco_out;
    logic        restart;
    logic        core_rst;
    logic        running;
    logic        done;
    logic [1:0]  status;
    logic [31:0] cycle_cnt;
    logic [31:0] last_pc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         fixed_pc;
        int         halt_k;
        int         abort_k;
        int         restart_k;
        logic [1:0] exp_status;
        int         exp_cnt;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    core_run_monitor u_dut (
        .clk       (clk),
        .rst       (rst),
        .instr_t   (instr_t),
        .pco_out   (pco_out),
        .restart   (restart),
        .core_rst  (core_rst),
        .running   (running),
        .done      (done),
        .status    (status),
        .cycle_cnt (cycle_cnt),
        .last_pc   (last_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pc_at(input bit fixed_pc, input int k);
        return fixed_pc ? 32'h40 : 32'(32'h1000 + 4 * k);
    endfunction

    // Drives one run (RUN cycle k gets pc_at(k)); returns when done rises or the run is aborted.
    task automatic run_vec(input int idx, input vec_t v, output bit ok);
        int k = 0;
        ok = 1'b0;
        for (int guard = 0; guard < 1000; guard++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (running) begin
                k++;
                pco_out = pc_at(v.fixed_pc, k);
                instr_t = (k == v.halt_k) ? ECALL : NOP;
                restart = (k == v.restart_k);
                if (k == v.abort_k) begin
                    #2 rst = 1'b1;
                    #1;
                    check($sformatf("v%0d_abort_core_rst", idx), core_rst, 1);
                    check($sformatf("v%0d_abort_running", idx), running, 0);
                    check($sformatf("v%0d_abort_status", idx), status, 0);
                    check($sformatf("v%0d_abort_cnt", idx), cycle_cnt, 0);
                    check($sformatf("v%0d_abort_last_pc", idx), last_pc, 0);
                    @(negedge clk);
                    rst = 1'b0;
                    ok  = 1'b1;
                    return;
                end
            end else begin
                restart = 1'b0;
            end
        end
    endtask

    initial begin
        bit ok;
        vecs[0] = '{0, 10,  0, 0, 2'b01, 14};
        vecs[1] = '{1, 0,   0, 0, 2'b11, 17};
        vecs[2] = '{0, 0,   0, 0, 2'b10, 500};
        vecs[3] = '{0, 500, 0, 0, 2'b01, 504};
        vecs[4] = '{1, 17,  0, 0, 2'b01, 21};
        vecs[5] = '{1, 5,   0, 0, 2'b01, 9};
        vecs[6] = '{0, 1,   0, 0, 2'b01, 5};
        vecs[7] = '{0, 3,   5, 0, 2'b00, 0};
        vecs[8] = '{0, 10,  0, 2, 2'b01, 14};

        rst     = 1'b1;
        restart = 1'b0;
        instr_t = NOP;
        pco_out = '0;
        repeat (2) @(negedge clk);
        check("rst_core_rst", core_rst, 1);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_status", status, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_last_pc", last_pc, 0);

        rst = 1'b0;
        @(negedge clk);
        check("hold1_core_rst", core_rst, 1);
        check("hold1_running", running, 0);
        @(negedge clk);
        check("run1_core_rst", core_rst, 0);
        check("run1_running", running, 1);
        check("run1_cnt", cycle_cnt, 0);
        pco_out = 32'h1004;
        @(negedge clk);
        check("run2_cnt", cycle_cnt, 1);
        pco_out = 32'h1008;
        @(negedge clk);
        check("run3_cnt", cycle_cnt, 2);

        // Asynchronous reset mid-RUN, away from any clock edge
        #2 rst = 1'b1;
        #1;
        check("async_core_rst", core_rst, 1);
        check("async_running", running, 0);
        check("async_cnt", cycle_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i], ok);
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL v%0d_wait_done: done never rose within 1000 cycles", i);
                break;
            end
            if (vecs[i].abort_k != 0) continue;
            check($sformatf("v%0d_status", i), status, vecs[i].exp_status);
            check($sformatf("v%0d_cycle_cnt", i), cycle_cnt, vecs[i].exp_cnt);
            check($sformatf("v%0d_last_pc", i), last_pc,
                  pc_at(vecs[i].fixed_pc, vecs[i].exp_cnt));
            check($sformatf("v%0d_running", i), running, 0);
            check($sformatf("v%0d_core_rst", i), core_rst, 0);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_frozen_cnt", i), cycle_cnt, vecs[i].exp_cnt);
            check($sformatf("v%0d_frozen_done", i), done, 1);
            check($sformatf("v%0d_frozen_status", i), status, vecs[i].exp_status);
            restart = 1'b1;
            @(negedge clk);
            restart = 1'b0;
            check($sformatf("v%0d_rearm_done", i), done, 0);
            check($sformatf("v%0d_rearm_status", i), status, 0);
            check($sformatf("v%0d_rearm_cnt", i), cycle_cnt, 0);
            check($sformatf("v%0d_rearm_core_rst", i), core_rst, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
